// File: rtl/pll_lock_sequencer_pkg.sv
// State encodings and counter sizing shared by the PLL lock sequencer files.
// Encodings are exposed on seq_state for debug, so they are fixed values.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_ASSERT_RST = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABILISE  = 3'd2,
    ST_RELEASE    = 3'd3,
    ST_RUN        = 3'd4,
    ST_FAIL       = 3'd5
  } pll_seq_state_t;

  // Width of the single shared phase counter: large enough for the longest phase.
  function automatic int cnt_w(input int a, input int b, input int c, input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Control/status bundle between the lock sequencer (master) and the PLL/system side (slave).
// pll_locked is asynchronous; everything else is refclk-synchronous.
interface pll_lock_sequencer_if;

  logic       pll_locked;
  logic       restart_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       lock_fail;
  logic [2:0] seq_state;
  logic [1:0] retry_cnt;

  modport master (
    input  pll_locked,
    input  restart_req,
    output pll_rst,
    output sys_rst,
    output lock_fail,
    output seq_state,
    output retry_cnt
  );

  modport slave (
    output pll_locked,
    output restart_req,
    input  pll_rst,
    input  sys_rst,
    input  lock_fail,
    input  seq_state,
    input  retry_cnt
  );

endinterface

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single level signal; output lags input by 2 clk edges.
// Both stages clear to 0 on the asynchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset, lock wait (with timeout/retry), lock debounce and system reset release.
// Runs on refclk; outputs are registered and decoded from the next state so they track seq_state.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_HOLD_CYCLES    = 16,
  parameter int LOCK_TIMEOUT       = 50000,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RELEASE_DELAY      = 8,
  parameter int MAX_RETRIES        = 3
) (
  input  logic                 refclk,
  input  logic                 rst,
  pll_lock_sequencer_if.master bus
);

  localparam int CNT_W = cnt_w(RST_HOLD_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES,
                               RELEASE_DELAY, MAX_RETRIES);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_DELAY - 1);
  localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

  pll_seq_state_t   r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_retry;
  logic             r_pll_rst;
  logic             r_sys_rst;
  logic             r_lock_fail;

  logic             w_locked_sync;
  pll_seq_state_t   w_nxt_state;
  logic [1:0]       w_nxt_retry;
  logic [1:0]       w_retry_inc;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .i_d (bus.pll_locked),
    .o_q (w_locked_sync)
  );

  assign w_retry_inc = (r_retry == RETRY_MAX) ? r_retry : r_retry + 2'd1;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_retry = r_retry;
    if (bus.restart_req) begin
      w_nxt_state = ST_ASSERT_RST;
      w_nxt_retry = 2'd0;
    end else begin
      case (r_state)
        ST_ASSERT_RST: begin
          if (r_cnt == HOLD_LAST) w_nxt_state = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          // A lock seen on the timeout cycle still wins over the retry.
          if (w_locked_sync) begin
            w_nxt_state = ST_STABILISE;
          end else if (r_cnt == TIMEOUT_LAST) begin
            w_nxt_retry = w_retry_inc;
            w_nxt_state = (w_retry_inc == RETRY_MAX) ? ST_FAIL : ST_ASSERT_RST;
          end
        end
        ST_STABILISE: begin
          if (!w_locked_sync)              w_nxt_state = ST_WAIT_LOCK;
          else if (r_cnt == STABLE_LAST)   w_nxt_state = ST_RELEASE;
        end
        ST_RELEASE: begin
          if (!w_locked_sync)              w_nxt_state = ST_ASSERT_RST;
          else if (r_cnt == RELEASE_LAST)  w_nxt_state = ST_RUN;
        end
        ST_RUN: begin
          if (!w_locked_sync) begin
            w_nxt_state = ST_ASSERT_RST;
            w_nxt_retry = 2'd0;
          end
        end
        ST_FAIL: begin
          w_nxt_state = ST_FAIL;
        end
        default: begin
          w_nxt_state = ST_ASSERT_RST;
        end
      endcase
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_ASSERT_RST;
      r_cnt       <= '0;
      r_retry     <= 2'd0;
      r_pll_rst   <= 1'b1;
      r_sys_rst   <= 1'b1;
      r_lock_fail <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_retry <= w_nxt_retry;
      // Restart re-enters ASSERT_RST even when already there, so it restarts the hold too.
      if ((w_nxt_state != r_state) || bus.restart_req)
        r_cnt <= '0;
      else if ((r_state != ST_RUN) && (r_state != ST_FAIL))
        r_cnt <= r_cnt + CNT_W'(1);
      r_pll_rst   <= (w_nxt_state == ST_ASSERT_RST) || (w_nxt_state == ST_FAIL);
      r_sys_rst   <= (w_nxt_state != ST_RUN);
      r_lock_fail <= (w_nxt_state == ST_FAIL);
    end
  end

  assign bus.pll_rst   = r_pll_rst;
  assign bus.sys_rst   = r_sys_rst;
  assign bus.lock_fail = r_lock_fail;
  assign bus.seq_state = r_state;
  assign bus.retry_cnt = r_retry;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short phase parameters.
// All sampling and driving happens 1 ns after a refclk rising edge.
module tb_pll_lock_sequencer;
  import pll_seq_pkg::*;

  logic refclk = 1'b0;
  logic rst    = 1'b1;
  int   n_cmp  = 0;
  int   n_err  = 0;

  pll_lock_sequencer_if bus ();

  always #5 refclk = ~refclk;

  pll_lock_sequencer #(
    .RST_HOLD_CYCLES    (4),
    .LOCK_TIMEOUT       (20),
    .LOCK_STABLE_CYCLES (8),
    .RELEASE_DELAY      (3),
    .MAX_RETRIES        (2)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output int n);
    n = 0;
    while (bus.seq_state !== s && n < budget) begin
      tick(1);
      n++;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.pll_locked  = 1'b0;
    bus.restart_req = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.pll_locked  = 1'b0;
    bus.restart_req = 1'b0;
    tick(3);
    n_cmp++; if (bus.pll_rst !== 1'b1)    begin n_err++; $display("FAIL reset_pll_rst got=%b exp=1", bus.pll_rst); end
    n_cmp++; if (bus.sys_rst !== 1'b1)    begin n_err++; $display("FAIL reset_sys_rst got=%b exp=1", bus.sys_rst); end
    n_cmp++; if (bus.lock_fail !== 1'b0)  begin n_err++; $display("FAIL reset_lock_fail got=%b exp=0", bus.lock_fail); end
    n_cmp++; if (bus.seq_state !== 3'd0)  begin n_err++; $display("FAIL reset_state got=%0d exp=0", bus.seq_state); end
    n_cmp++; if (bus.retry_cnt !== 2'd0)  begin n_err++; $display("FAIL reset_retry got=%0d exp=0", bus.retry_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    int n;
    tick(3);
    n_cmp++; if (bus.pll_rst !== 1'b1) begin n_err++; $display("FAIL nom_hold3 got=%b exp=1", bus.pll_rst); end
    tick(1);
    n_cmp++; if (bus.pll_rst !== 1'b0) begin n_err++; $display("FAIL nom_hold4 got=%b exp=0", bus.pll_rst); end
    n_cmp++; if (bus.seq_state !== ST_WAIT_LOCK) begin n_err++; $display("FAIL nom_wait got=%0d exp=1", bus.seq_state); end
    tick(4);
    bus.pll_locked = 1'b1;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (bus.sys_rst !== 1'b0 && n < 40);
    n_cmp++; if (n != 14) begin n_err++; $display("FAIL nom_release_latency got=%0d exp=14", n); end
    n_cmp++; if (bus.seq_state !== ST_RUN) begin n_err++; $display("FAIL nom_run got=%0d exp=4", bus.seq_state); end
    n_cmp++; if (bus.pll_rst !== 1'b0) begin n_err++; $display("FAIL nom_run_pll_rst got=%b exp=0", bus.pll_rst); end
  endtask

  task automatic test_retry_then_run();
    int n;
    apply_reset();
    tick(4);
    n_cmp++; if (bus.seq_state !== ST_WAIT_LOCK) begin n_err++; $display("FAIL retry_wait got=%0d exp=1", bus.seq_state); end
    tick(19);
    n_cmp++; if (bus.seq_state !== ST_WAIT_LOCK) begin n_err++; $display("FAIL retry_wait19 got=%0d exp=1", bus.seq_state); end
    tick(1);
    n_cmp++; if (bus.seq_state !== ST_ASSERT_RST) begin n_err++; $display("FAIL retry_timeout got=%0d exp=0", bus.seq_state); end
    n_cmp++; if (bus.retry_cnt !== 2'd1) begin n_err++; $display("FAIL retry_cnt1 got=%0d exp=1", bus.retry_cnt); end
    n_cmp++; if (bus.pll_rst !== 1'b1) begin n_err++; $display("FAIL retry_pll_rst got=%b exp=1", bus.pll_rst); end
    bus.pll_locked = 1'b1;
    wait_state(ST_RUN, 60, n);
    n_cmp++; if (bus.seq_state !== ST_RUN) begin n_err++; $display("FAIL retry_reach_run got=%0d exp=4", bus.seq_state); end
    n_cmp++; if (bus.retry_cnt !== 2'd1) begin n_err++; $display("FAIL retry_run_cnt got=%0d exp=1", bus.retry_cnt); end
  endtask

  task automatic test_lock_loss();
    int n;
    bus.pll_locked = 1'b0;
    tick(2);
    n_cmp++; if (bus.sys_rst !== 1'b0) begin n_err++; $display("FAIL loss_early got=%b exp=0", bus.sys_rst); end
    tick(1);
    n_cmp++; if (bus.sys_rst !== 1'b1) begin n_err++; $display("FAIL loss_sys_rst got=%b exp=1", bus.sys_rst); end
    n_cmp++; if (bus.seq_state !== ST_ASSERT_RST) begin n_err++; $display("FAIL loss_state got=%0d exp=0", bus.seq_state); end
    n_cmp++; if (bus.retry_cnt !== 2'd0) begin n_err++; $display("FAIL loss_retry got=%0d exp=0", bus.retry_cnt); end
    bus.pll_locked = 1'b1;
    wait_state(ST_RUN, 60, n);
    n_cmp++; if (bus.seq_state !== ST_RUN) begin n_err++; $display("FAIL loss_reseq got=%0d exp=4", bus.seq_state); end
    n_cmp++; if (bus.retry_cnt !== 2'd0) begin n_err++; $display("FAIL loss_reseq_retry got=%0d exp=0", bus.retry_cnt); end
  endtask

  task automatic test_glitch();
    int n;
    apply_reset();
    bus.pll_locked = 1'b1;
    wait_state(ST_STABILISE, 20, n);
    n_cmp++; if (bus.seq_state !== ST_STABILISE) begin n_err++; $display("FAIL glitch_stab got=%0d exp=2", bus.seq_state); end
    tick(3);
    bus.pll_locked = 1'b0;
    tick(1);
    bus.pll_locked = 1'b1;
    tick(1);
    n_cmp++; if (bus.seq_state !== ST_STABILISE) begin n_err++; $display("FAIL glitch_cnt5 got=%0d exp=2", bus.seq_state); end
    tick(1);
    n_cmp++; if (bus.seq_state !== ST_WAIT_LOCK) begin n_err++; $display("FAIL glitch_drop got=%0d exp=1", bus.seq_state); end
    tick(1);
    n_cmp++; if (bus.seq_state !== ST_STABILISE) begin n_err++; $display("FAIL glitch_relock got=%0d exp=2", bus.seq_state); end
    tick(10);
    n_cmp++; if (bus.sys_rst !== 1'b1) begin n_err++; $display("FAIL glitch_hold got=%b exp=1", bus.sys_rst); end
    n_cmp++; if (bus.seq_state !== ST_RELEASE) begin n_err++; $display("FAIL glitch_release got=%0d exp=3", bus.seq_state); end
    tick(1);
    n_cmp++; if (bus.sys_rst !== 1'b0) begin n_err++; $display("FAIL glitch_deassert got=%b exp=0", bus.sys_rst); end
    n_cmp++; if (bus.retry_cnt !== 2'd0) begin n_err++; $display("FAIL glitch_retry got=%0d exp=0", bus.retry_cnt); end
  endtask

  task automatic test_timeout_fail();
    apply_reset();
    tick(3);
    n_cmp++; if (bus.pll_rst !== 1'b1) begin n_err++; $display("FAIL to_pulse1_hi got=%b exp=1", bus.pll_rst); end
    tick(1);
    n_cmp++; if (bus.pll_rst !== 1'b0) begin n_err++; $display("FAIL to_pulse1_lo got=%b exp=0", bus.pll_rst); end
    tick(19);
    n_cmp++; if (bus.pll_rst !== 1'b0) begin n_err++; $display("FAIL to_wait1 got=%b exp=0", bus.pll_rst); end
    tick(1);
    n_cmp++; if (bus.pll_rst !== 1'b1) begin n_err++; $display("FAIL to_pulse2_hi got=%b exp=1", bus.pll_rst); end
    n_cmp++; if (bus.retry_cnt !== 2'd1) begin n_err++; $display("FAIL to_retry1 got=%0d exp=1", bus.retry_cnt); end
    tick(3);
    n_cmp++; if (bus.pll_rst !== 1'b1) begin n_err++; $display("FAIL to_pulse2_hold got=%b exp=1", bus.pll_rst); end
    tick(1);
    n_cmp++; if (bus.pll_rst !== 1'b0) begin n_err++; $display("FAIL to_pulse2_lo got=%b exp=0", bus.pll_rst); end
    tick(19);
    n_cmp++; if (bus.seq_state !== ST_WAIT_LOCK) begin n_err++; $display("FAIL to_wait2 got=%0d exp=1", bus.seq_state); end
    tick(1);
    n_cmp++; if (bus.seq_state !== ST_FAIL) begin n_err++; $display("FAIL to_fail_state got=%0d exp=5", bus.seq_state); end
    n_cmp++; if (bus.lock_fail !== 1'b1) begin n_err++; $display("FAIL to_lock_fail got=%b exp=1", bus.lock_fail); end
    n_cmp++; if (bus.retry_cnt !== 2'd2) begin n_err++; $display("FAIL to_retry2 got=%0d exp=2", bus.retry_cnt); end
    n_cmp++; if (bus.pll_rst !== 1'b1) begin n_err++; $display("FAIL to_fail_pll_rst got=%b exp=1", bus.pll_rst); end
    n_cmp++; if (bus.sys_rst !== 1'b1) begin n_err++; $display("FAIL to_fail_sys_rst got=%b exp=1", bus.sys_rst); end
    bus.pll_locked = 1'b1;
    tick(30);
    n_cmp++; if (bus.seq_state !== ST_FAIL) begin n_err++; $display("FAIL to_sticky got=%0d exp=5", bus.seq_state); end
    n_cmp++; if (bus.lock_fail !== 1'b1) begin n_err++; $display("FAIL to_sticky_flag got=%b exp=1", bus.lock_fail); end
  endtask

  task automatic test_restart_fail();
    int n;
    bus.restart_req = 1'b1;
    tick(1);
    bus.restart_req = 1'b0;
    n_cmp++; if (bus.seq_state !== ST_ASSERT_RST) begin n_err++; $display("FAIL rsf_state got=%0d exp=0", bus.seq_state); end
    n_cmp++; if (bus.lock_fail !== 1'b0) begin n_err++; $display("FAIL rsf_lock_fail got=%b exp=0", bus.lock_fail); end
    n_cmp++; if (bus.retry_cnt !== 2'd0) begin n_err++; $display("FAIL rsf_retry got=%0d exp=0", bus.retry_cnt); end
    n_cmp++; if (bus.sys_rst !== 1'b1) begin n_err++; $display("FAIL rsf_sys_rst got=%b exp=1", bus.sys_rst); end
    wait_state(ST_RUN, 60, n);
    n_cmp++; if (bus.seq_state !== ST_RUN) begin n_err++; $display("FAIL rsf_reach_run got=%0d exp=4", bus.seq_state); end
  endtask

  task automatic test_restart_run();
    bus.restart_req = 1'b1;
    tick(1);
    bus.restart_req = 1'b0;
    n_cmp++; if (bus.seq_state !== ST_ASSERT_RST) begin n_err++; $display("FAIL rsr_state got=%0d exp=0", bus.seq_state); end
    n_cmp++; if (bus.sys_rst !== 1'b1) begin n_err++; $display("FAIL rsr_sys_rst got=%b exp=1", bus.sys_rst); end
    n_cmp++; if (bus.pll_rst !== 1'b1) begin n_err++; $display("FAIL rsr_pll_rst got=%b exp=1", bus.pll_rst); end
    n_cmp++; if (bus.lock_fail !== 1'b0) begin n_err++; $display("FAIL rsr_lock_fail got=%b exp=0", bus.lock_fail); end
  endtask

  task automatic test_async_rst();
    int n;
    wait_state(ST_RELEASE, 40, n);
    n_cmp++; if (bus.seq_state !== ST_RELEASE) begin n_err++; $display("FAIL ar_reach_release got=%0d exp=3", bus.seq_state); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.pll_rst !== 1'b1) begin n_err++; $display("FAIL ar_pll_rst got=%b exp=1", bus.pll_rst); end
    n_cmp++; if (bus.sys_rst !== 1'b1) begin n_err++; $display("FAIL ar_sys_rst got=%b exp=1", bus.sys_rst); end
    n_cmp++; if (bus.seq_state !== ST_ASSERT_RST) begin n_err++; $display("FAIL ar_state got=%0d exp=0", bus.seq_state); end
    n_cmp++; if (bus.lock_fail !== 1'b0) begin n_err++; $display("FAIL ar_lock_fail got=%b exp=0", bus.lock_fail); end
    tick(2);
    rst = 1'b0;
    tick(4);
    n_cmp++; if (bus.seq_state !== ST_WAIT_LOCK) begin n_err++; $display("FAIL ar_restart_wait got=%0d exp=1", bus.seq_state); end
    tick(1);
    n_cmp++; if (bus.seq_state !== ST_STABILISE) begin n_err++; $display("FAIL ar_restart_stab got=%0d exp=2", bus.seq_state); end
    wait_state(ST_RUN, 40, n);
    n_cmp++; if (bus.sys_rst !== 1'b0) begin n_err++; $display("FAIL ar_restart_run got=%b exp=0", bus.sys_rst); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_retry_then_run();
    test_lock_loss();
    test_glitch();
    test_timeout_fail();
    test_restart_fail();
    test_restart_run();
    test_async_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
